shift_arbiter: RTL

SHIFT_ARBITER -- requirements
Module: shift_arbiter

---
 rtl/shift_arbiter_if.sv | 42 ++++
 rtl/shift_arbiter.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/shift_arbiter_if.sv
// shift_arbiter_if -- bundle of every non-clock signal around shift_arbiter.
//
// Groups three ports:
//   request  : reqValid/reqReady handshake plus reqData, reqLeft and reqCount,
//              which hold two requesters side by side (requester i owns bit i,
//              byte i and nibble i).
//   shifter  : srEnable/srLoad/srShiftLeft/srDatain drive an external 8-bit
//              bidirectional shift register; srDataout returns its contents.
//   response : rspValid/rspReady handshake with rspId and rspData.
//
// Modports:
//   slave  -- the arbiter side (shift_arbiter uses this one).
//   master -- the environment side: the requesters, the shift register and
//             the result consumer.
interface shift_arbiter_if;
  logic [1:0]  reqValid;
  logic [1:0]  reqReady;
  logic [15:0] reqData;
  logic [1:0]  reqLeft;
  logic [7:0]  reqCount;
  logic        srEnable;
  logic        srLoad;
  logic        srShiftLeft;
  logic [7:0]  srDatain;
  logic [7:0]  srDataout;
  logic        rspValid;
  logic        rspReady;
  logic        rspId;
  logic [7:0]  rspData;

  modport slave (
    input  reqValid, reqData, reqLeft, reqCount, srDataout, rspReady,
    output reqReady, srEnable, srLoad, srShiftLeft, srDatain,
           rspValid, rspId, rspData
  );

  modport master (
    output reqValid, reqData, reqLeft, reqCount, srDataout, rspReady,
    input  reqReady, srEnable, srLoad, srShiftLeft, srDatain,
           rspValid, rspId, rspData
  );
endinterface

// File: rtl/shift_arbiter.sv
// shift_arbiter -- arbitrates two requesters onto one external 8-bit
// bidirectional shift register.
//
// A command carries a load byte, a direction and a shift count. The command is
// handled in four steps:
//   1. The command is accepted in IDLE.
//   2. LOAD puts the byte into the shift register.
//   3. SHIFT shifts the register once per cycle, count times. A count above 8
//      is clamped to 8.
//   4. RESP presents the register contents until the consumer accepts them.
// Only one command is in flight at a time.
//
// Ports:
//   clock -- rising-edge clock for all state.
//   reset -- asynchronous, active-high. It forces IDLE and discards any
//            operation in flight.
//   bus   -- shift_arbiter_if.slave. It carries the request, shifter and
//            response ports.
//
// Configuration:
//   SHIFT_ARB_ROUND_ROBIN_EN
//     Defined   : under contention, the requester not granted last wins.
//     Undefined : fixed priority. Requester 0 always wins contention, and no
//                 last-grant state exists.
module shift_arbiter (
  input  logic           clock,
  input  logic           reset,
  shift_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, RESP} state_t;

  state_t     state;
  logic [3:0] cnt;          // shifts still to perform
  logic       dir;          // captured direction, 1 = left
  logic       sr_enable;
  logic       sr_load;
  logic       sr_shift_left;
  logic [7:0] sr_datain;    // doubles as the captured load byte
  logic       rsp_valid;
  logic       rsp_id;

`ifdef SHIFT_ARB_ROUND_ROBIN_EN
  logic       last_grant;
`endif

  logic       winner;
  logic [1:0] grant;
  logic [7:0] sel_data;
  logic [3:0] sel_count;

  // Arbitration and the IDLE accept are combinational so that the transfer
  // happens in the same cycle the winner presents reqValid.
  always_comb begin
    // NOTE: every always_comb output gets a default first. A path that leaves
    // a signal unassigned would infer a latch.
    winner = ~bus.reqValid[0];
    grant  = 2'b00;
`ifdef SHIFT_ARB_ROUND_ROBIN_EN
    if (&bus.reqValid) winner = ~last_grant;
`endif
    // The grant is also masked during reset so reqReady reads 00 while reset
    // is held.
    if (state == IDLE && !reset && bus.reqValid[winner]) grant[winner] = 1'b1;
    sel_data  = winner ? bus.reqData[15:8] : bus.reqData[7:0];
    sel_count = winner ? bus.reqCount[7:4] : bus.reqCount[3:0];
  end

  // rspData mirrors the register directly. A registered copy taken when
  // entering RESP would catch the value from before the final shift.
  assign bus.rspData     = (state == RESP) ? bus.srDataout : 8'h00;
  assign bus.reqReady    = grant;
  assign bus.srEnable    = sr_enable;
  assign bus.srLoad      = sr_load;
  assign bus.srShiftLeft = sr_shift_left;
  assign bus.srDatain    = sr_datain;
  assign bus.rspValid    = rsp_valid;
  assign bus.rspId       = rsp_id;

  // NOTE: sequential state uses non-blocking assignments only. All registers
  // then update together at the edge, whatever the statement order.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      cnt           <= 4'd0;
      dir           <= 1'b0;
      sr_enable     <= 1'b0;
      sr_load       <= 1'b0;
      sr_shift_left <= 1'b0;
      sr_datain     <= 8'h00;
      rsp_valid     <= 1'b0;
      rsp_id        <= 1'b0;
`ifdef SHIFT_ARB_ROUND_ROBIN_EN
      last_grant    <= 1'b1;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (|grant) begin
            state         <= LOAD;
            sr_enable     <= 1'b1;
            sr_load       <= 1'b1;
            sr_shift_left <= 1'b0;
            sr_datain     <= sel_data;
            dir           <= bus.reqLeft[winner];
            cnt           <= (sel_count > 4'd8) ? 4'd8 : sel_count;
            rsp_id        <= winner;
`ifdef SHIFT_ARB_ROUND_ROBIN_EN
            last_grant    <= winner;
`endif
          end
        end
        LOAD: begin
          sr_load <= 1'b0;
          if (cnt != 4'd0) begin
            state         <= SHIFT;
            sr_shift_left <= dir;
          end else begin
            state     <= RESP;
            sr_enable <= 1'b0;
            rsp_valid <= 1'b1;
          end
        end
        SHIFT: begin
          // cnt holds the shifts left including this one, so cnt == 1 is
          // the last shift cycle.
          if (cnt == 4'd1) begin
            state         <= RESP;
            sr_enable     <= 1'b0;
            sr_shift_left <= 1'b0;
            rsp_valid     <= 1'b1;
          end
          cnt <= cnt - 4'd1;
        end
        RESP: begin
          if (bus.rspReady) begin
            state     <= IDLE;
            rsp_valid <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
